// File: rtl/mux_scanner.sv
// mux_scanner: round-robin scanner in front of an 8:1 select mux.
// Steps the select through channels 0..7, waits DWELL cycles on each so
// the mux output settles, captures one bit per channel and hands the
// assembled 8-bit frame downstream on a valid/ready handshake.
// Optional build macro MUX_SCANNER_PARITY_EN adds a registered
// frame_parity output (XOR of the frame bits).
module mux_scanner #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic [2:0] s,
  input  logic       y,
  output logic [7:0] frame,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       busy
`ifdef MUX_SCANNER_PARITY_EN
  ,
  output logic       frame_parity
`endif
);

  localparam int CNT_W = $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Capture register is kept apart from frame so a partial scan never
  // shows up on the output.
  logic [7:0]       cap_q, cap_d;
  logic [7:0]       frame_q, frame_d;
  logic             fv_q, fv_d;
`ifdef MUX_SCANNER_PARITY_EN
  logic             par_q, par_d;
`endif

  // Next-state and datapath update for the scan sequence.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    frame_d = frame_q;
    fv_d    = fv_q;
`ifdef MUX_SCANNER_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        s_d = 3'd0;
        if (start) begin
          state_d = SCAN;
          cnt_d   = '0;
        end
      end
      SCAN: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          cap_d[s_q] = y;
          if (s_q == 3'd7) begin
            // Last channel: publish the frame straight from the capture
            // bits plus the live sample, select returns to channel 0.
            frame_d = {y, cap_q[6:0]};
            fv_d    = 1'b1;
`ifdef MUX_SCANNER_PARITY_EN
            par_d   = ^{y, cap_q[6:0]};
`endif
            state_d = DONE;
            s_d     = 3'd0;
          end else begin
            s_d   = s_q + 3'd1;
            cnt_d = '0;
          end
        end
      end
      DONE: begin
        s_d = 3'd0;
        if (frame_ready) begin
          fv_d = 1'b0;
          if (start) begin
            state_d = SCAN;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        s_d     = 3'd0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Select, dwell counter, capture and frame registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_q     <= 3'd0;
      cnt_q   <= '0;
      cap_q   <= 8'h00;
      frame_q <= 8'h00;
      fv_q    <= 1'b0;
`ifdef MUX_SCANNER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      frame_q <= frame_d;
      fv_q    <= fv_d;
`ifdef MUX_SCANNER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign s           = s_q;
  assign frame       = frame_q;
  assign frame_valid = fv_q;
  assign busy        = (state_q == SCAN);
`ifdef MUX_SCANNER_PARITY_EN
  assign frame_parity = par_q;
`endif

endmodule

// File: tb/tb_mux_scanner.sv
// tb_mux_scanner: bench for mux_scanner with an 8:1 mux model y = d[s].
// Instance A (DWELL=4) is tracked every cycle by a timeline model based
// on edges elapsed since the scan was accepted; instance B (DWELL=1) is
// checked with directed expectations.
module tb_mux_scanner;

  localparam int DW_A = 4;
  localparam int DW_B = 1;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       startA, readyA, startB, readyB;
  logic [7:0] dA, dB;
  logic [2:0] sA, sB;
  logic       yA, yB;
  logic [7:0] frameA, frameB;
  logic       fvA, fvB, busyA, busyB;
`ifdef MUX_SCANNER_PARITY_EN
  logic       parA, parB;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  assign yA = dA[sA];
  assign yB = dB[sB];

  mux_scanner #(.DWELL(DW_A)) u_a (
    .clk(clk), .reset_n(reset_n), .start(startA), .s(sA), .y(yA),
    .frame(frameA), .frame_valid(fvA), .frame_ready(readyA), .busy(busyA)
`ifdef MUX_SCANNER_PARITY_EN
    , .frame_parity(parA)
`endif
  );

  mux_scanner #(.DWELL(DW_B)) u_b (
    .clk(clk), .reset_n(reset_n), .start(startB), .s(sB), .y(yB),
    .frame(frameB), .frame_valid(fvB), .frame_ready(readyB), .busy(busyB)
`ifdef MUX_SCANNER_PARITY_EN
    , .frame_parity(parB)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: 0=idle, 1=scanning, 2=frame waiting.
  // m_n counts edges since the scan was accepted; channel i is sampled
  // on the edge that makes the count reach (i+1)*DWELL.
  int         m_st = 0;
  int         m_n = 0;
  logic [7:0] m_acc = 8'h00;
  logic [7:0] m_frame = 8'h00;
  logic       m_valid = 1'b0;

  function automatic int samp_ch(input int n);
    return (n + 1) / DW_A - 1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_st <= 0; m_n <= 0; m_acc <= 8'h00; m_frame <= 8'h00; m_valid <= 1'b0;
    end else begin
      case (m_st)
        0: if (startA) begin m_st <= 1; m_n <= 0; m_acc <= 8'h00; end
        1: begin
          m_n <= m_n + 1;
          if (((m_n + 1) % DW_A) == 0) begin
            m_acc <= m_acc | (8'({7'b0, dA[samp_ch(m_n)]}) << samp_ch(m_n));
            if (samp_ch(m_n) == 7) begin
              m_frame <= m_acc | (8'({7'b0, dA[7]}) << 7);
              m_valid <= 1'b1;
              m_st    <= 2;
            end
          end
        end
        default: if (readyA) begin
          m_valid <= 1'b0;
          if (startA) begin m_st <= 1; m_n <= 0; m_acc <= 8'h00; end
          else m_st <= 0;
        end
      endcase
    end
  end

  // Compare instance A against the model on every falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("s", 32'(sA), (m_st == 1) ? 32'(m_n / DW_A) : 32'd0);
      chk("busy", 32'(busyA), 32'(m_st == 1));
      chk("frame_valid", 32'(fvA), 32'(m_valid));
      chk("frame", 32'(frameA), 32'(m_frame));
`ifdef MUX_SCANNER_PARITY_EN
      chk("frame_parity", 32'(parA), 32'(^m_frame));
`endif
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_a();
    readyA = 1'b1; cyc(1); readyA = 1'b0;
  endtask

  int bc;

  initial begin
    reset_n = 1'b1; startA = 1'b0; readyA = 1'b0; dA = 8'h00;
    startB = 1'b0; readyB = 1'b0; dB = 8'h00;
    #1 reset_n = 1'b0;
    cyc(2);
    chk("rst_s", 32'(sA), 32'd0);
    chk("rst_frame", 32'(frameA), 32'd0);
    chk("rst_valid", 32'(fvA), 32'd0);
    chk("rst_busy", 32'(busyA), 32'd0);
    reset_n = 1'b1;
    chk_en = 1'b1;
    cyc(1);

    // Basic scan of 8'hA6, busy for exactly 32 cycles.
    dA = 8'hA6; startA = 1'b1; cyc(1); startA = 1'b0;
    bc = 0;
    for (int i = 0; i < 40; i++) begin
      if (busyA) bc++;
      cyc(1);
    end
    chk("busy_cycles", 32'(bc), 32'd32);
    chk("frame_A6", 32'(frameA), 32'h A6);
    chk("valid_A6", 32'(fvA), 32'd1);
`ifdef MUX_SCANNER_PARITY_EN
    chk("parity_A6", 32'(parA), 32'd0);
`endif

    // Backpressure: data and start change, frame must hold.
    dA = 8'h3C;
    for (int i = 0; i < 20; i++) begin
      startA = (i == 5);
      cyc(1);
    end
    startA = 1'b0;
    chk("hold_frame", 32'(frameA), 32'h A6);
    chk("hold_valid", 32'(fvA), 32'd1);
    chk("hold_s", 32'(sA), 32'd0);

    // Back-to-back: handshake and start on the same edge.
    readyA = 1'b1; startA = 1'b1; cyc(1); readyA = 1'b0; startA = 1'b0;
    chk("b2b_valid", 32'(fvA), 32'd0);
    chk("b2b_busy", 32'(busyA), 32'd1);
    cyc(32);
    chk("frame_3C", 32'(frameA), 32'h 3C);
    chk("valid_3C", 32'(fvA), 32'd1);
`ifdef MUX_SCANNER_PARITY_EN
    chk("parity_3C", 32'(parA), 32'd0);
`endif
    ack_a();
    chk("idle_valid", 32'(fvA), 32'd0);
    chk("idle_busy", 32'(busyA), 32'd0);

    dA = 8'h01; startA = 1'b1; cyc(1); startA = 1'b0;
    cyc(32);
    chk("frame_01", 32'(frameA), 32'h 01);
`ifdef MUX_SCANNER_PARITY_EN
    chk("parity_01", 32'(parA), 32'd1);
`endif
    ack_a();

    // Reset in the middle of channel 5.
    dA = 8'hFF; startA = 1'b1; cyc(1); startA = 1'b0;
    cyc(21);
    chk("pre_rst_s", 32'(sA), 32'd5);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_s", 32'(sA), 32'd0);
    chk("arst_busy", 32'(busyA), 32'd0);
    chk("arst_frame", 32'(frameA), 32'd0);
    chk("arst_valid", 32'(fvA), 32'd0);
    cyc(1);
    reset_n = 1'b1;
    cyc(1);
    dA = 8'h0F; startA = 1'b1; cyc(1); startA = 1'b0;
    cyc(32);
    chk("frame_0F", 32'(frameA), 32'h 0F);
    ack_a();

    // Channel 2 input changes during its dwell, then after its sample.
    dA = 8'h00; startA = 1'b1; cyc(1); startA = 1'b0;
    cyc(10);
    dA = 8'h04;
    cyc(2);
    dA = 8'h00;
    cyc(20);
    chk("frame_middwell", 32'(frameA), 32'h 04);
    ack_a();

    // Randomized traffic, model-checked every cycle.
    for (int i = 0; i < 600; i++) begin
      cyc(1);
      if ($urandom_range(0, 7) == 0) dA = 8'($urandom);
      startA = ($urandom_range(0, 3) == 0);
      readyA = ($urandom_range(0, 2) == 0);
    end
    startA = 1'b0; readyA = 1'b0;
    cyc(2);

    // DWELL=1 instance: select advances every cycle.
    dB = 8'h81; startB = 1'b1; cyc(1); startB = 1'b0;
    for (int j = 0; j < 8; j++) begin
      chk("d1_s", 32'(sB), 32'(j));
      chk("d1_valid_low", 32'(fvB), 32'd0);
      chk("d1_busy", 32'(busyB), 32'd1);
      cyc(1);
    end
    chk("d1_valid", 32'(fvB), 32'd1);
    chk("d1_frame", 32'(frameB), 32'h 81);
    chk("d1_s_done", 32'(sB), 32'd0);
`ifdef MUX_SCANNER_PARITY_EN
    chk("d1_parity", 32'(parB), 32'd0);
`endif
    readyB = 1'b1; cyc(1); readyB = 1'b0;
    chk("d1_ack", 32'(fvB), 32'd0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
